// File: rtl/codebook_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codebook_encoder_pkg
// Description : Shared state encoding, sizes and RGB field positions for the
//               codebook encoder.
// Revision    : 1.0  initial release
// ============================================================================
package codebook_encoder_pkg;

    localparam int c_cb_size = 64;
    localparam int c_pix_num = 4096;
    localparam int c_addr_w  = 20;
    localparam int c_data_w  = 24;
    localparam int c_tag_w   = 6;
    localparam int c_dist_w  = 10;

    localparam int c_ch_w    = 8;
    localparam int c_r_lsb   = 16;
    localparam int c_g_lsb   = 8;
    localparam int c_b_lsb   = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CB   = 3'd1,
        FETCH_PIX = 3'd2,
        SEARCH    = 3'd3,
        WRITE     = 3'd4,
        DONE      = 3'd5
    } state_t;

    function automatic logic [c_ch_w-1:0] abs_diff(input logic [c_ch_w-1:0] a,
                                                   input logic [c_ch_w-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/codebook_regfile.sv
`default_nettype none
// ============================================================================
// Module      : codebook_regfile
// Description : Codeword store, one synchronous write port and one
//               combinational read port. Contents survive reset.
// Revision    : 1.0  initial release
// ============================================================================
module codebook_regfile
    import codebook_encoder_pkg::*;
#(
    parameter int DEPTH = c_cb_size,
    parameter int WIDTH = c_data_w,
    parameter int IDX_W = c_tag_w
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/codebook_encoder.sv
`default_nettype none
// ============================================================================
// Module      : codebook_encoder
// Description : Loads the codebook, then tags every image pixel with the index
//               of its nearest codeword (sum of absolute channel differences).
// Revision    : 1.0  initial release
// ============================================================================
module codebook_encoder
    import codebook_encoder_pkg::*;
#(
    parameter int CB_SIZE = c_cb_size,
    parameter int PIX_NUM = c_pix_num,
    parameter int ADDR_W  = c_addr_w,
    parameter int DATA_W  = c_data_w,
    parameter int TAG_W   = c_tag_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] CB_A,
    output logic              CB_OE,
    input  logic [DATA_W-1:0] CB_Q,
    output logic [ADDR_W-1:0] IMG_A,
    output logic              IMG_OE,
    input  logic [DATA_W-1:0] IMG_Q,
    output logic [ADDR_W-1:0] TAG_A,
    output logic [TAG_W-1:0]  TAG_D,
    output logic              TAG_WE
);

    localparam int c_pix_w = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
    localparam logic [ADDR_W-1:0]  c_last_cb  = ADDR_W'(CB_SIZE - 1);
    localparam logic [TAG_W-1:0]   c_last_k   = TAG_W'(CB_SIZE - 1);
    localparam logic [c_pix_w-1:0] c_last_pix = c_pix_w'(PIX_NUM - 1);

    state_t               r_state;
    logic [c_pix_w-1:0]   r_pix_cnt;
    logic [TAG_W-1:0]     r_k;
    logic [TAG_W-1:0]     r_best_idx;
    logic [c_dist_w-1:0]  r_best_dist;
    logic [DATA_W-1:0]    r_pix;
    logic                 r_fetch_ph;
    logic                 r_cb_cap;
    logic [TAG_W-1:0]     r_cb_cap_idx;

    logic [DATA_W-1:0]    w_cw;
    logic [c_dist_w-1:0]  w_dist;
    logic                 w_take;
    logic [TAG_W-1:0]     w_best_idx_nxt;
    logic [c_dist_w-1:0]  w_best_dist_nxt;

    // CB_Q is only written the cycle after an address was issued with CB_OE
    codebook_regfile #(
        .DEPTH (CB_SIZE),
        .WIDTH (DATA_W),
        .IDX_W (TAG_W)
    ) u_regfile (
        .clk     (clk),
        .we      (r_cb_cap),
        .wr_idx  (r_cb_cap_idx),
        .wr_data (CB_Q),
        .rd_idx  (r_k),
        .rd_data (w_cw)
    );

    assign w_dist = c_dist_w'(abs_diff(r_pix[c_r_lsb +: c_ch_w], w_cw[c_r_lsb +: c_ch_w]))
                  + c_dist_w'(abs_diff(r_pix[c_g_lsb +: c_ch_w], w_cw[c_g_lsb +: c_ch_w]))
                  + c_dist_w'(abs_diff(r_pix[c_b_lsb +: c_ch_w], w_cw[c_b_lsb +: c_ch_w]));

    // strict compare keeps the lower index on ties
    assign w_take          = (r_k == '0) || (w_dist < r_best_dist);
    assign w_best_idx_nxt  = w_take ? r_k    : r_best_idx;
    assign w_best_dist_nxt = w_take ? w_dist : r_best_dist;

    assign busy = (r_state != IDLE) && (r_state != DONE);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            CB_A         <= '0;
            CB_OE        <= 1'b0;
            IMG_A        <= '0;
            IMG_OE       <= 1'b0;
            TAG_A        <= '0;
            TAG_D        <= '0;
            TAG_WE       <= 1'b0;
            r_pix_cnt    <= '0;
            r_k          <= '0;
            r_best_idx   <= '0;
            r_best_dist  <= '0;
            r_pix        <= '0;
            r_fetch_ph   <= 1'b0;
            r_cb_cap     <= 1'b0;
            r_cb_cap_idx <= '0;
        end else begin
            r_cb_cap     <= (r_state == LOAD_CB) && CB_OE;
            r_cb_cap_idx <= CB_A[TAG_W-1:0];
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= LOAD_CB;
                        r_pix_cnt <= '0;
                        CB_OE     <= 1'b1;
                        CB_A      <= '0;
                    end
                end
                LOAD_CB: begin
                    if (CB_OE) begin
                        if (CB_A == c_last_cb) begin
                            CB_OE <= 1'b0;
                        end else begin
                            CB_A <= CB_A + 1'b1;
                        end
                    end else begin
                        // drain cycle: last codeword is being captured now
                        CB_A       <= '0;
                        r_state    <= FETCH_PIX;
                        r_fetch_ph <= 1'b0;
                        IMG_OE     <= 1'b1;
                        IMG_A      <= ADDR_W'(r_pix_cnt);
                    end
                end
                FETCH_PIX: begin
                    if (!r_fetch_ph) begin
                        IMG_OE     <= 1'b0;
                        r_fetch_ph <= 1'b1;
                    end else begin
                        r_pix   <= IMG_Q;
                        r_k     <= '0;
                        r_state <= SEARCH;
                    end
                end
                SEARCH: begin
                    r_best_idx  <= w_best_idx_nxt;
                    r_best_dist <= w_best_dist_nxt;
                    r_k         <= r_k + 1'b1;
                    if (r_k == c_last_k) begin
                        r_state <= WRITE;
                        TAG_WE  <= 1'b1;
                        TAG_A   <= ADDR_W'(r_pix_cnt);
                        TAG_D   <= w_best_idx_nxt;
                    end
                end
                WRITE: begin
                    TAG_WE <= 1'b0;
                    if (r_pix_cnt == c_last_pix) begin
                        r_state <= DONE;
                    end else begin
                        r_pix_cnt  <= r_pix_cnt + 1'b1;
                        IMG_A      <= ADDR_W'(r_pix_cnt + 1'b1);
                        IMG_OE     <= 1'b1;
                        r_fetch_ph <= 1'b0;
                        r_state    <= FETCH_PIX;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/codebook_encoder.md
# codebook_encoder

Compression-side stage of the codebook image flow. It loads the 64-entry, 24-bit RGB codebook from the codebook RAM and reads each of the 4096 image pixels from the image RAM. For each pixel it finds the nearest codebook entry by sum of absolute differences, then writes the 6-bit index of that entry to the tag RAM. The tag RAM and codebook RAM it fills are exactly what the decompress controller consumes.

## Interface
Parameters:
- CB_SIZE, 64, number of codebook entries
- PIX_NUM, 4096, pixels per image
- ADDR_W, 20, RAM address width
- DATA_W, 24, pixel/codeword width ({R[23:16], G[15:8], B[7:0]})
- TAG_W, 6, tag width (log2 CB_SIZE)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a run
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high while in DONE
- CB_A  out  ADDR_W  codebook RAM address
- CB_OE  out  1  codebook RAM read enable
- CB_Q  in  DATA_W  codebook RAM data, valid the cycle after address/OE
- IMG_A  out  ADDR_W  image RAM address
- IMG_OE  out  1  image RAM read enable
- IMG_Q  in  DATA_W  image RAM data, valid the cycle after address/OE
- TAG_A  out  ADDR_W  tag RAM address
- TAG_D  out  TAG_W  tag RAM write data
- TAG_WE  out  1  tag RAM write enable

## Operation
- Reset (rst=0, any time, including mid-run):
  - State IDLE; all outputs 0.
  - Pixel counter, entry counter, best index and best distance cleared.
  - Codebook regfile contents are not cleared.
- IDLE: start=1 → LOAD_CB.
- LOAD_CB:
  - CB_OE=1, CB_A steps 0..63, one per cycle.
  - CB_Q is written into regfile entry (CB_A−1) on the following cycle.
  - After address 63 issues, one drain cycle with CB_OE=0 captures entry 63; then → FETCH_PIX.
  - Total 65 cycles.
- FETCH_PIX:
  - Cycle 1: IMG_OE=1, IMG_A=pixel counter.
  - Cycle 2: IMG_Q latched into the pixel register.
  - Then → SEARCH.
- SEARCH:
  - One entry per cycle, k=0..63.
  - dist = |R−Rk| + |G−Gk| + |B−Bk|, each channel unsigned 8-bit, sum 10-bit, no saturation.
  - k=0 loads best unconditionally; k>0 replaces best only if dist < best (strict, so ties keep the lower index).
  - After k=63 → WRITE.
- WRITE:
  - TAG_WE=1 for one cycle, TAG_A=pixel counter, TAG_D=best index.
  - If pixel counter = PIX_NUM−1 → DONE; else increment the counter and → FETCH_PIX.
- DONE:
  - done=1, all enables 0, held indefinitely.
  - start=1 → LOAD_CB with the pixel counter cleared (full new run, codebook reloaded).
- start while busy is ignored.
- Outputs are registered or decoded from registered state only; no combinational path from any input to any output.

## Timing
- Codebook load: 65 cycles from the first LOAD_CB cycle.
- Per pixel: 67 cycles (2 fetch + 64 search + 1 write).
- Run length:
  - The first TAG_WE occurs 65+66 = 131 cycles after the first LOAD_CB cycle.
  - done rises 65 + 4096×67 = 274 497 cycles after entering LOAD_CB.
- Read-data capture always happens one cycle after the matching OE/address cycle; the block never samples CB_Q/IMG_Q in any other cycle.
- TAG_A and TAG_D are stable throughout the TAG_WE cycle.
- Counter wrap: pixel counter stops at PIX_NUM−1 (no wrap); entry counter wraps 63→0 at the SEARCH exit.

## Structure
- Shared package holds:
  - state encoding: IDLE, LOAD_CB, FETCH_PIX, SEARCH, WRITE, DONE (3-bit);
  - CB_SIZE, PIX_NUM, DATA_W and TAG_W defaults;
  - the channel-field slice constants.
- One sub-module, codebook_regfile: 64×24 registers, one synchronous write port, one combinational read port indexed by the entry counter.
- The SAD datapath and best-tracking registers stay in the top module.

## Test plan
- Reset mid-SEARCH (rst low 3 cycles at pixel 10, k=20):
  - outputs all 0, state IDLE, no TAG_WE;
  - a subsequent start reproduces the full run from pixel 0.
- Codebook entry k = {k×4, k×4, k×4}, pixel 0 = 0x505050 → TAG_A=0, TAG_D=20, TAG_WE 131 cycles after the first LOAD_CB cycle.
- Tie: entries 3 and 7 both equal 0x102030, all other entries 0xFFFFFF, pixel 0x102030 → TAG_D=3.
- Channel extremes: pixel 0x000000 with entry 0 = 0xFFFFFF and entry 1 = 0x000001 → TAG_D=1; distance 765 does not overflow.
- Full 4096-pixel random image vs. reference model → every tag matches; done rises exactly 274 497 cycles after LOAD_CB entry; a second start in DONE reruns with identical tags.
- start pulses during LOAD_CB and SEARCH → ignored; cycle counts unchanged.
